// File: rtl/tt_query_arbiter_if.sv
// Bundle of the requester-side and TT-side signals around the query arbiter.
// The slave modport is the arbiter; the master modport is everything around it
// (the requesters and the TT core).
interface tt_query_arbiter_if #(
  parameter int N = 2
);
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [4*N-1:0] req_src;
  logic [4*N-1:0] req_dst;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [3:0]     rsp_cost;
  logic           rsp_err;
  logic           tt_in_valid;
  logic [3:0]     tt_source;
  logic [3:0]     tt_destination;
  logic           tt_out_valid;
  logic [3:0]     tt_cost;
  logic           busy;

  modport master (
    output req_valid, req_last, req_src, req_dst, tt_out_valid, tt_cost,
    input  req_ready, rsp_valid, rsp_cost, rsp_err,
    input  tt_in_valid, tt_source, tt_destination, busy
  );

  modport slave (
    input  req_valid, req_last, req_src, req_dst, tt_out_valid, tt_cost,
    output req_ready, rsp_valid, rsp_cost, rsp_err,
    output tt_in_valid, tt_source, tt_destination, busy
  );
endinterface

// File: rtl/tt_query_arbiter.sv
// Round-robin arbiter sharing one TT shortest-path core between N requesters.
// A granted requester's frame is forwarded to TT as one contiguous burst; the
// arbiter then waits (with a timeout) for TT's cost and returns it to the
// granted requester as a one-cycle strobe.
module tt_query_arbiter #(
  parameter int N       = 2,
  parameter int TIMEOUT = 1023
) (
  input logic              clk,
  input logic              rst,
  tt_query_arbiter_if.slave bus
);

  localparam int PW = (N > 2) ? 2 : 1;
  localparam logic [9:0] TMO_LIMIT = 10'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;

  state_t        state;
  logic [PW-1:0] gnt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] pick;
  logic [9:0]    tmo;
  logic          trunc;
  logic          started;

  logic          sel_valid;
  logic          sel_last;
  logic [3:0]    sel_src;
  logic [3:0]    sel_dst;
  logic [N-1:0]  gnt_onehot;

  // Round-robin search: first valid requester starting just after ptr.
  always_comb begin
    int  idx;
    logic found;
    pick  = ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && bus.req_valid[idx]) begin
        pick  = PW'(idx);
        found = 1'b1;
      end
    end
  end

  // Mux out the granted requester's beat fields and its one-hot response lane.
  always_comb begin
    sel_valid  = bus.req_valid[gnt];
    sel_last   = bus.req_last[gnt];
    sel_src    = bus.req_src[{gnt, 2'b00} +: 4];
    sel_dst    = bus.req_dst[{gnt, 2'b00} +: 4];
    gnt_onehot = {{(N-1){1'b0}}, 1'b1} << gnt;
  end

  // Only the granted requester may hand over beats, and only while sending.
  always_comb begin
    bus.req_ready = '0;
    if (state == SEND) bus.req_ready[gnt] = 1'b1;
  end

  // Control FSM with registered TT and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      gnt                <= '0;
      ptr                <= PW'(N - 1);
      tmo                <= '0;
      trunc              <= 1'b0;
      started            <= 1'b0;
      bus.rsp_valid      <= '0;
      bus.rsp_cost       <= '0;
      bus.rsp_err        <= 1'b0;
      bus.tt_in_valid    <= 1'b0;
      bus.tt_source      <= '0;
      bus.tt_destination <= '0;
      bus.busy           <= 1'b0;
    end else begin
      bus.tt_in_valid <= 1'b0;
      bus.rsp_valid   <= '0;
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            gnt      <= pick;
            ptr      <= pick;
            started  <= 1'b0;
            bus.busy <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (sel_valid) begin
            bus.tt_in_valid    <= 1'b1;
            bus.tt_source      <= sel_src;
            bus.tt_destination <= sel_dst;
            started            <= 1'b1;
            if (sel_last) begin
              tmo   <= '0;
              state <= WAIT;
            end
          end else if (started) begin
            trunc <= 1'b1;
            tmo   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.tt_out_valid) begin
            bus.rsp_cost  <= bus.tt_cost;
            bus.rsp_err   <= trunc;
            bus.rsp_valid <= gnt_onehot;
            state         <= RESP;
          end else if (tmo == TMO_LIMIT) begin
            bus.rsp_cost  <= 4'hF;
            bus.rsp_err   <= 1'b1;
            bus.rsp_valid <= gnt_onehot;
            state         <= RESP;
          end else begin
            tmo <= tmo + 10'd1;
          end
        end
        RESP: begin
          trunc    <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
